// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with 2-entry skid buffer, sync flush and NOP payload on empty slots.
// Latency 1 cycle when empty; in_ready is registered, so one extra beat lands in S when out_ready drops.
module pipe_stage_skid #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] m_nx;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] s_nx;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_ready   = rdy_q;
  assign out_valid  = (state != ST_EMPTY);
  assign out_data   = m_q;
  assign bubble_cnt = cnt_q;
  assign in_xfer    = in_valid & rdy_q;
  assign out_xfer   = out_valid & out_ready;

  always_comb begin
    level = 2'd0;
    case (state)
      ST_ONE:  level = 2'd1;
      ST_TWO:  level = 2'd2;
      default: level = 2'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    m_nx     = m_q;
    s_nx     = s_q;
    if (flush) begin
      // Input beat in this cycle is swallowed; an output beat still completes downstream.
      state_nx = ST_EMPTY;
      m_nx     = NOP_VALUE;
      s_nx     = NOP_VALUE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nx = ST_ONE;
            m_nx     = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_nx = in_data;
          end else if (in_xfer) begin
            state_nx = ST_TWO;
            s_nx     = in_data;
          end else if (out_xfer) begin
            state_nx = ST_EMPTY;
            m_nx     = NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_nx = ST_ONE;
            m_nx     = s_q;
            s_nx     = NOP_VALUE;
          end
        end
        default: begin
          state_nx = ST_EMPTY;
          m_nx     = NOP_VALUE;
          s_nx     = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
      m_q   <= NOP_VALUE;
      s_q   <= NOP_VALUE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      m_q   <= m_nx;
      s_q   <= s_nx;
      // Registered ready: drops on the same edge that fills S.
      rdy_q <= (state_nx != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_stats) begin
      cnt_q <= '0;
    end else if (out_ready && !out_valid && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus random bench for pipe_stage_skid with a queue scoreboard of accepted beats.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        flush;
  logic        clr_stats;
  logic [1:0]  level;
  logic [3:0]  bubble_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q[$];
  int          exp_bub = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W    (32),
    .NOP_VALUE (32'h0),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .clr_stats  (clr_stats),
    .level      (level),
    .bubble_cnt (bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, score the edge, then check post-edge state at the next negedge.
  task automatic cyc(input logic iv, input logic [31:0] id, input logic ordy,
                     input logic fl, input logic clr);
    bit was_empty;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
    #1;
    was_empty = (q.size() == 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else               check("out_data", out_data, q.pop_front());
    end
    if (fl) q.delete();
    else if (in_valid && in_ready) q.push_back(in_data);
    if (clr) exp_bub = 0;
    else if (ordy && was_empty && exp_bub < 15) exp_bub++;
    @(posedge clk);
    @(negedge clk);
    check("level", 32'(level), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() != 2));
    if (q.size() == 0) check("nop_data", out_data, 32'h0);
    check("bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bubble", 32'(bubble_cnt), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_in_ready_post", 32'(in_ready), 32'd1);
    check("rel_no_accept", 32'(level), 32'd0);

    // Streaming
    cyc(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    check("stream_data_22", out_data, 32'h22);
    cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    check("stream_level", 32'(level), 32'd1);
    check("stream_data_33", out_data, 32'h33);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Skid fill and drain
    cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    check("skid_level", 32'(level), 32'd2);
    check("skid_in_ready", 32'(in_ready), 32'd0);
    check("skid_head", out_data, 32'hA1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("skid_ready_back", 32'(in_ready), 32'd1);
    check("skid_second", out_data, 32'hA2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush collision in TWO
    cyc(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB3, 1'b1, 1'b1, 1'b0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_data", out_data, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Bubble counter saturation and clear
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("bubble_sat", 32'(bubble_cnt), 32'd15);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("bubble_clr", 32'(bubble_cnt), 32'd0);

    // Reset while beats are held
    cyc(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_data", out_data, 32'h0);
    q.delete();
    exp_bub = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release", 32'(in_ready), 32'd1);

    // Random stress
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 4 && q.size() != 0; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drain_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
